// File: rtl/tx_scheduler_if.sv
// Purpose: bundle of the receiver/FIFO/transmitter signals seen by tx_scheduler.
// Ports (signals):
//   in_token      receiver -> scheduler  IN token pulse
//   fifo_count    FIFO -> scheduler      bytes held in the transmit FIFO
//   is_txing      transmitter -> sched.  line enable, high while a packet is on the bus
//   send_data     scheduler -> tx        one-cycle DATA request
//   send_nak      scheduler -> tx        one-cycle NAK request
//   busy          status                 high whenever the scheduler is not idle
//   tx_done       status                 one-cycle pulse after is_txing falls
//   token_dropped status                 one-cycle pulse: token ignored while busy
//   start_timeout status                 one-cycle pulse: transmitter never started
//   data_pkt_cnt  status                 completed DATA packets (mod 256)
//   nak_pkt_cnt   status                 completed NAK packets (mod 256)
// Modports: master = scheduler side, slave = environment side.
interface tx_scheduler_if #(
   parameter int unsigned CNT_W = 7
);
   logic             in_token;
   logic [CNT_W-1:0] fifo_count;
   logic             is_txing;
   logic             send_data;
   logic             send_nak;
   logic             busy;
   logic             tx_done;
   logic             token_dropped;
   logic             start_timeout;
   logic [7:0]       data_pkt_cnt;
   logic [7:0]       nak_pkt_cnt;

   modport master (
      input  in_token, fifo_count, is_txing,
      output send_data, send_nak, busy, tx_done, token_dropped, start_timeout,
             data_pkt_cnt, nak_pkt_cnt
   );

   modport slave (
      output in_token, fifo_count, is_txing,
      input  send_data, send_nak, busy, tx_done, token_dropped, start_timeout,
             data_pkt_cnt, nak_pkt_cnt
   );
endinterface

// File: rtl/tx_scheduler.sv
// Purpose: sequences the USB transmitter per IN token. Chooses DATA when the FIFO
//   holds a full packet, otherwise NAK; waits a bus turnaround gap, issues a single
//   request pulse, then tracks is_txing until the packet completes.
// Ports:
//   clk    in  system clock, rising edge
//   n_rst  in  synchronous active-low reset
//   bus    tx_scheduler_if.master (token/FIFO/transmitter handshake and status)
module tx_scheduler #(
   parameter int unsigned PKT_BYTES    = 64,
   parameter int unsigned CNT_W        = 7,
   parameter int unsigned GAP_CYC      = 16,
   parameter int unsigned START_TO_CYC = 64
) (
   input  logic           clk,
   input  logic           n_rst,
   tx_scheduler_if.master bus
);

   // One timer serves both the gap and the start timeout; it must reach max-1.
   localparam int unsigned TMR_MAX = (GAP_CYC > START_TO_CYC) ? GAP_CYC : START_TO_CYC;
   localparam int unsigned TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
   localparam int unsigned PCNT_W  = 8;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_GAP        = 3'd1,
      S_ISSUE      = 3'd2,
      S_WAIT_START = 3'd3,
      S_WAIT_DONE  = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic                sel_data_q, sel_data_d;
   logic [PCNT_W-1:0]   data_cnt_q, data_cnt_d;
   logic [PCNT_W-1:0]   nak_cnt_q, nak_cnt_d;
   logic                send_data_q, send_data_d;
   logic                send_nak_q, send_nak_d;
   logic                busy_q, busy_d;
   logic                tx_done_q, tx_done_d;
   logic                dropped_q, dropped_d;
   logic                timeout_q, timeout_d;

   logic gap_end_c;
   logic start_expired_c;

   assign gap_end_c       = (tmr_q == TMR_W'(GAP_CYC - 1));
   assign start_expired_c = (tmr_q == TMR_W'(START_TO_CYC - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_token) state_d = S_GAP;
         end
         S_GAP: begin
            if (gap_end_c) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            state_d = S_WAIT_START;
         end
         S_WAIT_START: begin
            // A transmitter already running counts as started.
            if (bus.is_txing)          state_d = S_WAIT_DONE;
            else if (start_expired_c)  state_d = S_IDLE;
         end
         S_WAIT_DONE: begin
            if (!bus.is_txing) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values; everything here is registered below.
   always_comb begin
      tmr_d       = tmr_q;
      sel_data_d  = sel_data_q;
      data_cnt_d  = data_cnt_q;
      nak_cnt_d   = nak_cnt_q;
      send_data_d = 1'b0;
      send_nak_d  = 1'b0;
      tx_done_d   = 1'b0;
      timeout_d   = 1'b0;
      dropped_d   = bus.in_token && (state_q != S_IDLE);
      busy_d      = (state_d != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (bus.in_token) begin
               // FIFO level is frozen here; later FIFO changes do not matter.
               sel_data_d = (bus.fifo_count >= CNT_W'(PKT_BYTES));
               tmr_d      = '0;
            end
         end
         S_GAP: begin
            tmr_d = tmr_q + TMR_W'(1);
         end
         S_ISSUE: begin
            send_data_d = sel_data_q;
            send_nak_d  = !sel_data_q;
            tmr_d       = '0;
         end
         S_WAIT_START: begin
            tmr_d = tmr_q + TMR_W'(1);
            if (!bus.is_txing && start_expired_c) timeout_d = 1'b1;
         end
         S_WAIT_DONE: begin
            if (!bus.is_txing) begin
               tx_done_d = 1'b1;
               if (sel_data_q) data_cnt_d = data_cnt_q + PCNT_W'(1);
               else            nak_cnt_d  = nak_cnt_q + PCNT_W'(1);
            end
         end
         default: begin
            tmr_d = '0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         tmr_q       <= '0;
         sel_data_q  <= 1'b0;
         data_cnt_q  <= '0;
         nak_cnt_q   <= '0;
         send_data_q <= 1'b0;
         send_nak_q  <= 1'b0;
         busy_q      <= 1'b0;
         tx_done_q   <= 1'b0;
         dropped_q   <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         tmr_q       <= tmr_d;
         sel_data_q  <= sel_data_d;
         data_cnt_q  <= data_cnt_d;
         nak_cnt_q   <= nak_cnt_d;
         send_data_q <= send_data_d;
         send_nak_q  <= send_nak_d;
         busy_q      <= busy_d;
         tx_done_q   <= tx_done_d;
         dropped_q   <= dropped_d;
         timeout_q   <= timeout_d;
      end
   end

   assign bus.send_data     = send_data_q;
   assign bus.send_nak      = send_nak_q;
   assign bus.busy          = busy_q;
   assign bus.tx_done       = tx_done_q;
   assign bus.token_dropped = dropped_q;
   assign bus.start_timeout = timeout_q;
   assign bus.data_pkt_cnt  = data_cnt_q;
   assign bus.nak_pkt_cnt   = nak_cnt_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Purpose: self-checking bench for tx_scheduler. Pulse outputs are checked by a
//   cycle-stamped scoreboard; status outputs are checked inline by each test task.
module tb_tx_scheduler;

   localparam int unsigned CNT_W        = 7;
   localparam int unsigned PKT_BYTES    = 64;
   localparam int unsigned GAP_CYC      = 16;
   localparam int unsigned START_TO_CYC = 64;
   // Negedge where the token is driven -> negedge where the request pulse is visible.
   localparam int ISSUE_LAT = GAP_CYC + 2;

   localparam logic [4:0] EV_DATA    = 5'b00001;
   localparam logic [4:0] EV_NAK     = 5'b00010;
   localparam logic [4:0] EV_DONE    = 5'b00100;
   localparam logic [4:0] EV_DROP    = 5'b01000;
   localparam logic [4:0] EV_TIMEOUT = 5'b10000;

   typedef struct {
      int         cyc;
      logic [4:0] ev;
   } exp_t;

   logic clk = 1'b0;
   logic n_rst;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   exp_data = 0;
   int   exp_nak = 0;
   exp_t exp_q[$];
   logic [4:0] obs_ev;
   logic [4:0] want_ev;

   tx_scheduler_if #(.CNT_W(CNT_W)) bus ();

   tx_scheduler #(
      .PKT_BYTES   (PKT_BYTES),
      .CNT_W       (CNT_W),
      .GAP_CYC     (GAP_CYC),
      .START_TO_CYC(START_TO_CYC)
   ) dut (
      .clk  (clk),
      .n_rst(n_rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse scoreboard: every cycle with an expected or observed pulse is compared.
   always @(negedge clk) begin
      obs_ev  = {bus.start_timeout, bus.token_dropped, bus.tx_done, bus.send_nak, bus.send_data};
      want_ev = '0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
         if (exp_q[i].cyc == cyc) begin
            want_ev = want_ev | exp_q[i].ev;
            exp_q.delete(i);
         end
      end
      if (obs_ev !== 5'b0 || want_ev != 5'b0) begin
         checks++;
         if (obs_ev !== want_ev) begin
            errors++;
            $display("FAIL pulses cyc=%0d got=%b want=%b (timeout,dropped,tx_done,nak,data)",
                     cyc, obs_ev, want_ev);
         end
      end
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic push_ev(input int c, input logic [4:0] ev);
      exp_t e;
      e.cyc = c;
      e.ev  = ev;
      exp_q.push_back(e);
   endtask

   // One complete packet: token, wait for request, is_txing high for 'hold' cycles.
   // Returns on the negedge where tx_done is visible.
   task automatic run_pkt(input logic [CNT_W-1:0] fifo, input int hold, input bit drop_fifo);
      int n;
      bit is_data;
      tick;
      n = cyc;
      is_data = (int'(fifo) >= int'(PKT_BYTES));
      bus.fifo_count = fifo;
      bus.in_token   = 1'b1;
      push_ev(n + ISSUE_LAT, is_data ? EV_DATA : EV_NAK);
      tick;
      bus.in_token = 1'b0;
      if (drop_fifo) bus.fifo_count = '0;
      while (cyc < n + ISSUE_LAT) tick;
      bus.is_txing = 1'b1;
      repeat (hold) tick;
      bus.is_txing = 1'b0;
      push_ev(cyc + 1, EV_DONE);
      tick;
      if (is_data) exp_data++;
      else         exp_nak++;
   endtask

   task automatic test_reset;
      n_rst          = 1'b0;
      bus.in_token   = 1'b0;
      bus.fifo_count = '0;
      bus.is_txing   = 1'b0;
      repeat (3) tick;
      bus.in_token   = 1'b1;
      bus.fifo_count = CNT_W'(PKT_BYTES);
      tick;
      bus.in_token = 1'b0;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      checks++;
      if (bus.data_pkt_cnt !== 8'd0) begin errors++; $display("FAIL reset_data_cnt got=%0d want=0", bus.data_pkt_cnt); end
      checks++;
      if (bus.nak_pkt_cnt !== 8'd0) begin errors++; $display("FAIL reset_nak_cnt got=%0d want=0", bus.nak_pkt_cnt); end
      n_rst = 1'b1;
      repeat (2) tick;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b want=0", bus.busy); end
   endtask

   task automatic test_nak;
      run_pkt(CNT_W'(PKT_BYTES - 1), 40, 1'b0);
      checks++;
      if (bus.nak_pkt_cnt !== 8'(exp_nak)) begin errors++; $display("FAIL nak_cnt got=%0d want=%0d", bus.nak_pkt_cnt, 8'(exp_nak)); end
      checks++;
      if (bus.data_pkt_cnt !== 8'(exp_data)) begin errors++; $display("FAIL nak_data_cnt got=%0d want=%0d", bus.data_pkt_cnt, 8'(exp_data)); end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL nak_busy got=%b want=0", bus.busy); end
   endtask

   task automatic test_data;
      run_pkt(CNT_W'(PKT_BYTES), 10, 1'b0);
      checks++;
      if (bus.data_pkt_cnt !== 8'(exp_data)) begin errors++; $display("FAIL data_cnt got=%0d want=%0d", bus.data_pkt_cnt, 8'(exp_data)); end
      checks++;
      if (bus.nak_pkt_cnt !== 8'(exp_nak)) begin errors++; $display("FAIL data_nak_cnt got=%0d want=%0d", bus.nak_pkt_cnt, 8'(exp_nak)); end
   endtask

   task automatic test_timeout;
      int n;
      tick;
      n = cyc;
      bus.fifo_count = CNT_W'(PKT_BYTES);
      bus.in_token   = 1'b1;
      push_ev(n + ISSUE_LAT, EV_DATA);
      push_ev(n + ISSUE_LAT + START_TO_CYC, EV_TIMEOUT);
      tick;
      bus.in_token = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL gap_busy got=%b want=1", bus.busy); end
      while (cyc < n + ISSUE_LAT + START_TO_CYC - 1) tick;
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL wait_start_busy got=%b want=1", bus.busy); end
      tick;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%b want=0", bus.busy); end
      checks++;
      if (bus.data_pkt_cnt !== 8'(exp_data) || bus.nak_pkt_cnt !== 8'(exp_nak)) begin
         errors++;
         $display("FAIL timeout_cnts got=%0d/%0d want=%0d/%0d", bus.data_pkt_cnt, bus.nak_pkt_cnt, 8'(exp_data), 8'(exp_nak));
      end
   endtask

   // Tokens during GAP, WAIT_DONE and the tx_done edge are dropped; a token on the
   // tx_done-visible cycle is accepted. is_txing rises early (already high at WAIT_START).
   task automatic test_dropped;
      int n;
      int m;
      tick;
      n = cyc;
      bus.fifo_count = CNT_W'(PKT_BYTES);
      bus.in_token   = 1'b1;
      push_ev(n + ISSUE_LAT, EV_DATA);
      tick;
      bus.in_token = 1'b0;
      while (cyc < n + 4) tick;
      bus.in_token = 1'b1;
      push_ev(n + 5, EV_DROP);
      tick;
      bus.in_token = 1'b0;
      while (cyc < n + 10) tick;
      bus.is_txing = 1'b1;
      while (cyc < n + 25) tick;
      bus.in_token = 1'b1;
      push_ev(n + 26, EV_DROP);
      tick;
      bus.in_token = 1'b0;
      while (cyc < n + 30) tick;
      bus.is_txing = 1'b0;
      bus.in_token = 1'b1;
      push_ev(n + 31, EV_DONE | EV_DROP);
      tick;
      exp_data++;
      checks++;
      if (bus.data_pkt_cnt !== 8'(exp_data)) begin errors++; $display("FAIL drop_data_cnt got=%0d want=%0d", bus.data_pkt_cnt, 8'(exp_data)); end
      m = cyc;
      bus.fifo_count = CNT_W'(PKT_BYTES - 1);
      push_ev(m + ISSUE_LAT, EV_NAK);
      tick;
      bus.in_token = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL accept_after_done_busy got=%b want=1", bus.busy); end
      while (cyc < m + ISSUE_LAT) tick;
      bus.is_txing = 1'b1;
      repeat (5) tick;
      bus.is_txing = 1'b0;
      push_ev(cyc + 1, EV_DONE);
      tick;
      exp_nak++;
      checks++;
      if (bus.nak_pkt_cnt !== 8'(exp_nak)) begin errors++; $display("FAIL drop_nak_cnt got=%0d want=%0d", bus.nak_pkt_cnt, 8'(exp_nak)); end
   endtask

   task automatic test_reset_mid;
      int n;
      tick;
      n = cyc;
      bus.fifo_count = CNT_W'(PKT_BYTES);
      bus.in_token   = 1'b1;
      push_ev(n + ISSUE_LAT, EV_DATA);
      tick;
      bus.in_token = 1'b0;
      while (cyc < n + ISSUE_LAT) tick;
      bus.is_txing = 1'b1;
      repeat (5) tick;
      // is_txing falls on the reset edge: reset must suppress the tx_done it would cause.
      n_rst        = 1'b0;
      bus.is_txing = 1'b0;
      tick;
      exp_data = 0;
      exp_nak  = 0;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
      checks++;
      if (bus.data_pkt_cnt !== 8'd0 || bus.nak_pkt_cnt !== 8'd0) begin
         errors++;
         $display("FAIL rstmid_cnts got=%0d/%0d want=0/0", bus.data_pkt_cnt, bus.nak_pkt_cnt);
      end
      n_rst = 1'b1;
      repeat (3) tick;
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_idle_busy got=%b want=0", bus.busy); end
   endtask

   // 256 DATA packets, FIFO emptied right after each token; counter wraps to 0.
   task automatic test_back_to_back;
      for (int k = 0; k < 256; k++) begin
         run_pkt(CNT_W'(PKT_BYTES + (k % 8)), 2, 1'b1);
         checks++;
         if (bus.data_pkt_cnt !== 8'(exp_data)) begin
            errors++;
            $display("FAIL b2b_data_cnt pkt=%0d got=%0d want=%0d", k, bus.data_pkt_cnt, 8'(exp_data));
         end
      end
      checks++;
      if (bus.data_pkt_cnt !== 8'd0) begin errors++; $display("FAIL b2b_wrap got=%0d want=0", bus.data_pkt_cnt); end
      checks++;
      if (bus.nak_pkt_cnt !== 8'(exp_nak)) begin errors++; $display("FAIL b2b_nak_cnt got=%0d want=%0d", bus.nak_pkt_cnt, 8'(exp_nak)); end
   endtask

   task automatic test_drain;
      repeat (4) tick;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
      end
   endtask

   initial begin
      test_reset;
      test_nak;
      test_data;
      test_timeout;
      test_dropped;
      test_reset_mid;
      test_back_to_back;
      test_drain;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish cyc=%0d", cyc);
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
